seg7_scan: RTL

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_if.sv | 23 ++
 rtl/seg7_scan.sv | 97 +++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Signal bundle between a seven-segment scan driver and its user.
// The master supplies display content and settings; the slave drives the panel.
interface seg7_scan_if;
  logic [31:0] data_seg;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic        hold;
  logic [3:0]  bright;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        frame;

  modport master (
    output data_seg, dp_mask, blank_lz, hold, bright,
    input  seg_n, dp_n, an_n, frame
  );

  modport slave (
    input  data_seg, dp_mask, blank_lz, hold, bright,
    output seg_n, dp_n, an_n, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver with frame-synchronous shadowing,
// leading-zero blanking, PWM brightness and a one-cycle anti-ghosting gap.
module seg7_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam logic [15:0] DIV_M1 = 16'(SCAN_DIV - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  pwm_q, pwm_d;
  logic [31:0] shown_q, shown_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;

  logic        tick, wrap, en, blank;
  logic [3:0]  nib;
  logic [31:0] upper;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    tick    = (cnt_q == DIV_M1);
    wrap    = tick && (idx_q == 3'd7);
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;
    pwm_d   = pwm_q + 4'd1;
    shown_d = (wrap && !bus.hold) ? bus.data_seg : shown_q;
    mask_d  = (wrap && !bus.hold) ? bus.dp_mask  : mask_q;
    frame_d = wrap;

    en    = (bus.bright == 4'hF) || (pwm_q < bus.bright);
    // a digit is blanked when it and every more-significant nibble is zero
    upper = shown_q >> {idx_q, 2'b00};
    blank = bus.blank_lz && (idx_q != 3'd0) && (upper == 32'd0);
    nib   = shown_q[{idx_q, 2'b00} +: 4];

    // the tick cycle is dark so the next digit never sees the old segments
    if (tick || !en || blank) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = ~decode(nib);
      dp_d  = ~mask_q[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      shown_q <= '0;
      mask_q  <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      shown_q <= shown_d;
      mask_q  <= mask_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign bus.an_n  = an_q;
  assign bus.seg_n = seg_q;
  assign bus.dp_n  = dp_q;
  assign bus.frame = frame_q;

endmodule
